piho_result_collector: RTL and testbench
========================================

// Module: piho_result_collector
// PURPOSE
// Downstream stage of the PIHO lattice units. Launches N piho units with one
// shared restart pulse and waits until every unit asserts finish. Then sums
// their 64-bit x2sum accumulators and computes the recorded sample count.
// Presents {sum, samples, err} to the host/UART side over a valid/ready handshake.
// PARAMETERS
// N_UNITS   4   number of piho units collected (1..16)
// SITES     64  lattice sites per unit (odd+even BRAM depth sum)
// PORTS
// clk              in   1        clock
// rst              in   1        reset; synchronous, active-high
// start            in   1        1-cycle request to launch a run
// totallooptimes   in   32       loop count programmed into the units
// warmupskip       in   32       warm-up loops programmed into the units
// timeout_cycles   in   32       RUN watchdog limit; 0 = disabled
// unit_rst         out  1        restart pulse to all units
// unit_finish      in   N_UNITS  finish flag per unit
// unit_x2sum       in   64*N     unit i at [64i+63:64i]
// unit_looptimes   in   32*N     unit i at [32i+31:32i]
// busy             out  1        high in every state except IDLE
// res_valid        out  1        result available
// res_ready        in   1        host accepts result
// res_sum          out  72       sum of all unit x2sum values, zero-extended
// res_samples      out  48       (totallooptimes-warmupskip)*SITES*N_UNITS
// res_err          out  1        timeout, loop-count mismatch or warmupskip>=total
// BEHAVIOUR
// - Reset values: unit_rst=0, busy=0, res_valid=0, res_sum=0, res_samples=0,
//   res_err=0, and the FSM is in IDLE. Reset aborts any state immediately.
// - States: IDLE -> LAUNCH -> SETTLE -> RUN -> SUM -> PRESENT -> IDLE.
// - IDLE: when start=1, latch totallooptimes, warmupskip and timeout_cycles,
//   clear the accumulators, and go to LAUNCH. start is ignored in all other states.
// - LAUNCH: drive unit_rst=1 for exactly 1 cycle, then go to SETTLE.
// - SETTLE: 2 cycles with unit_rst=0. The units clear finish on the cycle after
//   their rst falls, so stale finish flags are ignored here. Then go to RUN.
// - RUN: wait until &unit_finish=1, then go to SUM.
//   - The watchdog counter starts at 0 on entry and increments each cycle.
//   - If timeout_cycles!=0 and count==timeout_cycles-1 with finish incomplete:
//     set err, go to SUM.
//   - If both events occur in the same cycle, finish wins and err stays clear.
// - SUM: one unit per cycle, index 0..N_UNITS-1, for N_UNITS cycles total.
//   - acc += zero-extended unit_x2sum[i].
//   - If unit_looptimes[i] != latched total, set err.
//   - Inputs are sampled live; units hold their outputs once finish is set.
// - Samples arithmetic:
//   - diff = total - warmupskip as 32-bit unsigned.
//   - If warmupskip >= total: samples=0 and err=1.
//   - Otherwise samples = diff*SITES*N_UNITS, truncated to 48 bits.
//   - samples is registered by the end of SUM; a multi-cycle shift is allowed.
// - PRESENT: res_valid=1 with res_sum/res_samples/res_err stable.
//   - On a cycle with res_valid & res_ready, the transfer completes and the FSM
//     goes to IDLE the next cycle.
//   - Results hold their values after the transfer until the next start.
//   - res_ready high before res_valid has no effect.
// - Latency: start to res_valid = 1+1+2+T_run+N_UNITS cycles, where T_run is
//   the number of RUN cycles.
// - Wrap-around: acc is 72 bits and must not overflow for N<=16. The watchdog
//   counter saturates and never wraps.
// TESTING
// - Launch waveform: N=4, start pulse -> unit_rst high exactly 1 cycle; finish=4'hF
//   held during SETTLE does not advance the FSM.
// - Good run: all finish at cycle 100, x2sum={10,20,30,40}, looptimes=total=1000,
//   warm=200 -> res_sum=100, res_samples=204800, res_err=0.
// - Timeout: timeout_cycles=50, unit 2 never finishes -> SUM entered at RUN
//   cycle 50, res_err=1.
// - Mismatch and warm-up error: unit 1 looptimes=999 -> res_err=1. Separately,
//   warm=total=500 -> samples=0, err=1.
// - Handshake: res_ready low for 7 cycles -> res_valid held with stable data;
//   start pulses during PRESENT are ignored; rst mid-RUN -> all outputs at reset
//   values next cycle.
// - Overflow: every x2sum=64'hFFFF_FFFF_FFFF_FFFF with N=4 ->
//   res_sum=72'h3_FFFF_FFFF_FFFF_FFFC.

Source files
------------

// File: rtl/piho_result_collector.sv
// piho_result_collector: launches N piho units with a shared restart pulse,
// waits for every unit to finish (with an optional watchdog), sums their
// x2sum accumulators one unit per cycle, computes the recorded sample count
// and presents {sum, samples, err} over a valid/ready handshake.
module piho_result_collector #(
    parameter int N_UNITS = 4,
    parameter int SITES   = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [31:0]             totallooptimes,
    input  logic [31:0]             warmupskip,
    input  logic [31:0]             timeout_cycles,
    output logic                    unit_rst,
    input  logic [N_UNITS-1:0]      unit_finish,
    input  logic [64*N_UNITS-1:0]   unit_x2sum,
    input  logic [32*N_UNITS-1:0]   unit_looptimes,
    output logic                    busy,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [71:0]             res_sum,
    output logic [47:0]             res_samples,
    output logic                    res_err
);

    localparam int IDX_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_UNITS - 1);
    // Samples per recorded loop across all units.
    localparam logic [47:0] SAMPLES_PER_LOOP = 48'(SITES * N_UNITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_SETTLE,
        S_RUN,
        S_SUM,
        S_PRESENT
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [31:0]       r_total;
    logic [31:0]       r_warm;
    logic [31:0]       r_tmo;
    logic [31:0]       r_wd;
    logic              r_settle;
    logic [IDX_W-1:0]  r_idx;
    logic [71:0]       r_acc;
    logic [47:0]       r_samples;
    logic              r_err;

    logic              w_all_fin;
    logic              w_timeout;
    logic [63:0]       w_x2sum;
    logic [31:0]       w_looptimes;
    logic [47:0]       w_diff48;
    logic [47:0]       w_samples;
    logic              w_warm_bad;

    assign w_all_fin   = &unit_finish;
    // Finish in the same cycle as the watchdog limit takes priority.
    assign w_timeout   = (r_tmo != 32'd0) && (r_wd == r_tmo - 32'd1) && !w_all_fin;
    assign w_x2sum     = unit_x2sum[64*int'(r_idx) +: 64];
    assign w_looptimes = unit_looptimes[32*int'(r_idx) +: 32];
    assign w_warm_bad  = (r_warm >= r_total);
    assign w_diff48    = {16'd0, r_total - r_warm};
    assign w_samples   = w_diff48 * SAMPLES_PER_LOOP;

    assign res_sum     = r_acc;
    assign res_samples = r_samples;
    assign res_err     = r_err;

    // State register; reset aborts any state.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_next    = r_state;
        unit_rst  = 1'b0;
        busy      = 1'b1;
        res_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_next = S_LAUNCH;
            end
            S_LAUNCH: begin
                unit_rst = 1'b1;
                w_next   = S_SETTLE;
            end
            S_SETTLE: begin
                // Units may still show stale finish flags here; ignore them.
                if (r_settle) w_next = S_RUN;
            end
            S_RUN: begin
                if (w_all_fin || w_timeout) w_next = S_SUM;
            end
            S_SUM: begin
                if (r_idx == LAST_IDX) w_next = S_PRESENT;
            end
            S_PRESENT: begin
                res_valid = 1'b1;
                if (res_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Run configuration, watchdog, accumulation and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_total   <= 32'd0;
            r_warm    <= 32'd0;
            r_tmo     <= 32'd0;
            r_wd      <= 32'd0;
            r_settle  <= 1'b0;
            r_idx     <= '0;
            r_acc     <= 72'd0;
            r_samples <= 48'd0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_total   <= totallooptimes;
                        r_warm    <= warmupskip;
                        r_tmo     <= timeout_cycles;
                        r_wd      <= 32'd0;
                        r_settle  <= 1'b0;
                        r_idx     <= '0;
                        r_acc     <= 72'd0;
                        r_samples <= 48'd0;
                        r_err     <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    r_settle <= ~r_settle;
                end
                S_RUN: begin
                    if (r_wd != 32'hFFFF_FFFF) r_wd <= r_wd + 32'd1;
                    if (w_timeout) r_err <= 1'b1;
                end
                S_SUM: begin
                    r_acc <= r_acc + {8'd0, w_x2sum};
                    r_idx <= r_idx + 1'b1;
                    if (w_looptimes != r_total) r_err <= 1'b1;
                    if (r_idx == '0) begin
                        r_samples <= w_warm_bad ? 48'd0 : w_samples;
                        if (w_warm_bad) r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_piho_result_collector.sv
// Bench for piho_result_collector (N_UNITS=4, SITES=64). A run-level model
// derives every expected output from the run parameters and the cycle the
// bench releases finish; one negedge process compares the DUT every cycle.
module tb_piho_result_collector;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [31:0]  totallooptimes, warmupskip, timeout_cycles;
    logic         unit_rst;
    logic [3:0]   unit_finish;
    logic [255:0] unit_x2sum;
    logic [127:0] unit_looptimes;
    logic         busy, res_valid, res_ready;
    logic [71:0]  res_sum;
    logic [47:0]  res_samples;
    logic         res_err;

    piho_result_collector #(.N_UNITS(4), .SITES(64)) dut (
        .clk(clk), .rst(rst), .start(start),
        .totallooptimes(totallooptimes), .warmupskip(warmupskip),
        .timeout_cycles(timeout_cycles), .unit_rst(unit_rst),
        .unit_finish(unit_finish), .unit_x2sum(unit_x2sum),
        .unit_looptimes(unit_looptimes), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .res_sum(res_sum), .res_samples(res_samples),
        .res_err(res_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state, owned by the driver.
    bit          chk_en = 0;
    bit          exp_zero = 1;
    int          run_id = 0;
    int          s_cyc = 0;
    int          valid_cyc = 0;
    logic [71:0] m_sum;
    logic [47:0] m_samples;
    logic        m_err;

    // Literal-check requests handed to the compare process.
    int          lit_seq = 0;
    string       lit_name;
    logic [71:0] lit_act, lit_exp;

    // Values captured on the first res_valid cycle of a run.
    int          cap_v;
    logic [71:0] cap_sum;
    logic [47:0] cap_smp;
    logic        cap_err;

    // Counters, owned by the compare process.
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Compare process: every cycle against the model.
    initial begin
        int seen_id = -1;
        int xfer = -1;
        int lit_done = 0;
        bit ev, eb;
        forever begin
            @(negedge clk);
            if (lit_seq != lit_done) begin
                chk(lit_name, lit_act, lit_exp);
                lit_done = lit_seq;
            end
            if (chk_en) begin
                if (exp_zero) begin
                    chk("rst_busy", 72'(busy), 72'd0);
                    chk("rst_unit_rst", 72'(unit_rst), 72'd0);
                    chk("rst_valid", 72'(res_valid), 72'd0);
                    chk("rst_sum", res_sum, 72'd0);
                    chk("rst_samples", 72'(res_samples), 72'd0);
                    chk("rst_err", 72'(res_err), 72'd0);
                end else begin
                    if (run_id != seen_id) begin
                        seen_id = run_id;
                        xfer = -1;
                    end
                    ev = (cyc >= valid_cyc) && (xfer < 0 || cyc <= xfer);
                    if (ev && res_ready && xfer < 0) xfer = cyc;
                    eb = (cyc > s_cyc) && (xfer < 0 || cyc <= xfer);
                    chk("unit_rst", 72'(unit_rst), 72'(cyc == s_cyc + 1));
                    chk("busy", 72'(busy), 72'(eb));
                    chk("res_valid", 72'(res_valid), 72'(ev));
                    if (cyc >= valid_cyc) begin
                        chk("res_sum", res_sum, m_sum);
                        chk("res_samples", 72'(res_samples), 72'(m_samples));
                        chk("res_err", 72'(res_err), 72'(m_err));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (res_valid && cap_v < 0) begin
            cap_v   = cyc;
            cap_sum = res_sum;
            cap_smp = res_samples;
            cap_err = res_err;
        end
    endtask

    task automatic lit(input string nm, input logic [71:0] act, input logic [71:0] exp);
        lit_name = nm;
        lit_act  = act;
        lit_exp  = exp;
        lit_seq++;
        tick();
    endtask

    // One complete run. fin_at: RUN cycle (1-based) at which all units finish,
    // 0 = never (never_mask held instead). stale: finish=F through SETTLE.
    task automatic run(input logic [31:0] tot, input logic [31:0] warm,
                       input logic [31:0] tmo, input int fin_at,
                       input logic [3:0] never_mask,
                       input logic [63:0] x0, input logic [63:0] x1,
                       input logic [63:0] x2, input logic [63:0] x3,
                       input logic [31:0] l0, input logic [31:0] l1,
                       input logic [31:0] l2, input logic [31:0] l3,
                       input int rdy_dly, input bit stale, input bit start_pp);
        int t_run;
        bit tmo_hit;
        unit_x2sum     = {x3, x2, x1, x0};
        unit_looptimes = {l3, l2, l1, l0};
        unit_finish    = stale ? 4'hF : 4'h0;
        totallooptimes = tot;
        warmupskip     = warm;
        timeout_cycles = tmo;
        start          = 1'b1;
        // Model: run length, sum, samples and error from the rules.
        tmo_hit = (tmo != 0) && (fin_at == 0 || fin_at > int'(tmo));
        t_run   = tmo_hit ? int'(tmo) : fin_at;
        m_sum   = 72'(x0) + 72'(x1) + 72'(x2) + 72'(x3);
        m_samples = (warm >= tot) ? 48'd0 : 48'(48'(tot - warm) * 48'd256);
        m_err   = tmo_hit || (warm >= tot) ||
                  (l0 != tot) || (l1 != tot) || (l2 != tot) || (l3 != tot);
        s_cyc     = cyc;
        valid_cyc = cyc + 4 + t_run + 4;
        cap_v     = -1;
        exp_zero  = 0;
        run_id++;
        tick();
        start = 1'b0;
        while (cyc < valid_cyc + rdy_dly) begin
            if (cyc >= s_cyc + 4)
                unit_finish = (fin_at > 0 && cyc >= s_cyc + 3 + fin_at) ? 4'hF : never_mask;
            start     = (start_pp && cyc == valid_cyc + 2);
            res_ready = (cyc == s_cyc + 5);
            tick();
        end
        start     = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready   = 1'b0;
        unit_finish = 4'h0;
        tick();
        tick();
    endtask

    localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        rst = 1'b1; start = 1'b0; res_ready = 1'b0;
        totallooptimes = '0; warmupskip = '0; timeout_cycles = '0;
        unit_finish = '0; unit_x2sum = '0; unit_looptimes = '0;
        cap_v = -1;
        tick();
        chk_en = 1;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Launch waveform with stale finish flags held through SETTLE.
        run(10, 2, 0, 5, 4'h0, 1, 2, 3, 4, 10, 10, 10, 10, 0, 1, 0);
        lit("stale_latency", 72'(cap_v - s_cyc), 72'd13);
        lit("stale_samples", 72'(cap_smp), 72'd2048);

        // Good run.
        run(1000, 200, 0, 100, 4'h0, 10, 20, 30, 40, 1000, 1000, 1000, 1000, 0, 0, 0);
        lit("good_latency", 72'(cap_v - s_cyc), 72'd108);
        lit("good_sum", cap_sum, 72'd100);
        lit("good_samples", 72'(cap_smp), 72'd204800);
        lit("good_err", 72'(cap_err), 72'd0);

        // Timeout: unit 2 never finishes.
        run(1000, 200, 50, 0, 4'b1011, 10, 20, 30, 40, 1000, 1000, 1000, 1000, 0, 0, 0);
        lit("tmo_latency", 72'(cap_v - s_cyc), 72'd58);
        lit("tmo_err", 72'(cap_err), 72'd1);

        // Finish and watchdog limit in the same cycle: finish wins.
        run(1000, 200, 20, 20, 4'h0, 5, 6, 7, 8, 1000, 1000, 1000, 1000, 0, 0, 0);
        lit("tie_latency", 72'(cap_v - s_cyc), 72'd28);
        lit("tie_err", 72'(cap_err), 72'd0);

        // Loop-count mismatch on unit 1.
        run(1000, 200, 0, 3, 4'h0, 1, 1, 1, 1, 1000, 999, 1000, 1000, 0, 0, 0);
        lit("mismatch_err", 72'(cap_err), 72'd1);

        // warmupskip == total.
        run(500, 500, 0, 3, 4'h0, 1, 1, 1, 1, 500, 500, 500, 500, 0, 0, 0);
        lit("warm_samples", 72'(cap_smp), 72'd0);
        lit("warm_err", 72'(cap_err), 72'd1);

        // Handshake: ready low 7 cycles, start pulse during PRESENT ignored.
        run(300, 100, 0, 4, 4'h0, 64'h1234, 64'h10, 64'h20, 64'h30,
            300, 300, 300, 300, 7, 0, 1);

        // Overflow: all-ones accumulators.
        run(100, 0, 0, 2, 4'h0, ALL1, ALL1, ALL1, ALL1, 100, 100, 100, 100, 0, 0, 0);
        lit("ovf_sum", cap_sum, 72'h3_FFFF_FFFF_FFFF_FFFC);
        lit("ovf_samples", 72'(cap_smp), 72'd25600);

        // Reset in the middle of RUN.
        totallooptimes = 1000; warmupskip = 200; timeout_cycles = 0;
        unit_finish = 4'h0;
        start = 1'b1;
        s_cyc = cyc; valid_cyc = cyc + 100000; exp_zero = 0; run_id++;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        exp_zero = 1;
        rst = 1'b0;
        repeat (3) tick();

        // Normal operation after the abort.
        run(20, 4, 0, 1, 4'h0, 7, 8, 9, 10, 20, 20, 20, 20, 1, 0, 0);
        lit("post_rst_sum", cap_sum, 72'd34);
        lit("post_rst_samples", 72'(cap_smp), 72'd4096);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
